mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 16-bit RAM/SDRAM port (ram_* handshake bus) between two masters: m0 = CPU processor port, m1 = aux
//  master (UART loader/DMA). Sits between the masters and ram/sdram_block; grants one transaction at a time, sequences the
//  busy/rd_ready/rd_ack handshake and returns read data, done and error status to the granted master.
// PARAMETERS
//  ADDR_W      24   address width, all ports
//  DATA_W      16   data width, all ports
//  RD_TIMEOUT  255  max cycles in WAIT_RD before abort; counter width $clog2(RD_TIMEOUT+1)
// PORTS
//  clk           in   1       clock (mclk domain); single clock
//  rst           in   1       reset; synchronous, active-high
//  mN_addr       in   ADDR_W  master N address (N=0,1), held stable while request pending
//  mN_wr_data    in   DATA_W  master N write data, held stable while request pending
//  mN_wr_en      in   1       master N write request (level, held until mN_done)
//  mN_rd_en      in   1       master N read request (level, held until mN_done)
//  mN_rd_data    out  DATA_W  read data, valid in mN_done cycle, held until next read completion for N
//  mN_done       out  1       one-cycle completion pulse to master N
//  mN_err        out  1       read timeout flag, valid with mN_done only
//  ram_addr      out  ADDR_W  latched address of granted transaction
//  ram_wr_data   out  DATA_W  latched write data
//  ram_wr_en     out  1       one-cycle write strobe
//  ram_rd_en     out  1       one-cycle read strobe
//  ram_busy      in   1       memory cannot accept a strobe this cycle
//  ram_rd_data   in   DATA_W  memory read data, valid with ram_rd_ready
//  ram_rd_ready  in   1       read data available
//  ram_rd_ack    out  1       read data consumed (combinational, same cycle as accepted ram_rd_ready)
// BEHAVIOUR
//  Reset: state IDLE; all out regs 0 (ram_addr, ram_wr_data, mN_rd_data, mN_done, mN_err, strobes, ack, timeout cnt);
//   RR pointer favours m1 next (i.e. m0 wins first tie).
//  FSM: IDLE -> ISSUE -> (write) DONE | (read) WAIT_RD -> DONE -> IDLE.
//  IDLE: if any mN_rd_en|mN_wr_en: pick winner, latch addr, wr_data, op, owner; -> ISSUE. Else stay.
//  Same master with wr_en and rd_en both high: treated as write; rd_en ignored for that transaction.
//  ISSUE: while ram_busy=1 stay, no strobe. When ram_busy=0: ram_wr_en or ram_rd_en =1 (comb. from state&op&!busy)
//   exactly one cycle; write -> DONE; read -> WAIT_RD, timeout cnt cleared.
//  WAIT_RD: ram_rd_ready=1 -> ram_rd_ack=1 same cycle, capture ram_rd_data into mN_rd_data of owner, -> DONE.
//   Else cnt++; cnt==RD_TIMEOUT -> DONE with err set, mN_rd_data of owner unchanged. Ready and timeout same cycle: ready wins.
//  DONE: owner mN_done=1 (registered, one cycle), mN_err as set; other master's done=0; -> IDLE.
//  Masters drop en in cycle after seeing done; IDLE re-samples, so no double grant.
//  Latency (ram_busy=0): write req@c0 -> strobe c1 -> done c2. Read: strobe c1, ready@ck (k>=2) -> done ck+1.
//  Stray ram_rd_ready outside WAIT_RD: ram_rd_ack=1 to drain, data discarded, no state change.
//  Non-owner requests are held pending (no done) until current transaction finishes; never dropped.
//  Reset mid-transaction: next edge -> IDLE, strobes/ack 0, no done emitted; masters must re-issue.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; on tie winner = master not granted last; pointer updates on each grant.
//  Not defined: fixed priority, m0 (CPU) always wins ties; m1 served only when m0 idle. No pointer reg.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic[1:0] {ARB_IDLE,ARB_ISSUE,ARB_WAIT_RD,ARB_DONE} arb_state_t;
//   typedef enum logic {OP_RD,OP_WR} arb_op_t; localparam ARB_NMASTERS=2.
//  Sub-module mem_arb_pick: combinational winner select + RR pointer reg (MEM_ARB_RR_EN); FSM/datapath in mem_arbiter.
// TESTING
//  1 m0 write addr 24'h000010 data 16'hA5A5, busy=0 -> ram_wr_en 1 cycle c1 with those values, m0_done c2, m1_done 0.
//  2 m1 read 24'h000020, model returns 16'h1234 ready 3 cycles after strobe -> ack same cycle, m1_rd_data=16'h1234 with done.
//  3 m0,m1 request same cycle x4 back-to-back -> RR_EN: grants m0,m1,m0,m1; without: all m0 grants first, m1 after m0 idle.
//  4 ram_busy held 5 cycles in ISSUE -> no strobe during busy, single strobe on first busy=0 cycle, addr stable throughout.
//  5 read, ram_rd_ready never asserted -> done+err after RD_TIMEOUT cycles in WAIT_RD, rd_data unchanged; next req served.
//  6 rst pulsed in WAIT_RD -> IDLE next edge, no done, ack 0; stray ram_rd_ready in IDLE -> ack 1, state unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter.
// Holds FSM state, operation encoding and master count.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_RD,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } arb_op_t;

    localparam int ARB_NMASTERS = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the arbiter: 0 = m0 (CPU), 1 = m1 (aux).
// Ports: clk, rst (sync, active-high), req (per-master request),
//   grant (a grant is being taken this cycle), win (selected master).
// MEM_ARB_RR_EN defined: round-robin on ties, else m0 fixed priority.
import mem_arb_pkg::*;

module mem_arb_pick (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ARB_NMASTERS-1:0] req,
    input  logic                    grant,
    output logic                    win
);

`ifdef MEM_ARB_RR_EN
    // Master granted last; resets to m1 so m0 takes the first tie.
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= win;
        end
    end

    always_comb begin
        win = 1'b0;
        case (req)
            2'b11:   win = ~last_q;
            2'b10:   win = 1'b1;
            default: win = 1'b0;
        endcase
    end
`else
    logic unused_pick;

    assign unused_pick = &{1'b0, clk, rst, grant};
    assign win = req[1] & ~req[0];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single 16-bit RAM/SDRAM handshake port.
// Ports: clk, rst (sync, active-high); per master mN_addr, mN_wr_data,
//   mN_wr_en, mN_rd_en in; mN_rd_data, mN_done, mN_err out.
//   Memory side: ram_addr, ram_wr_data, ram_wr_en, ram_rd_en,
//   ram_rd_ack out; ram_busy, ram_rd_data, ram_rd_ready in.
// Build option: MEM_ARB_RR_EN selects round-robin tie breaking.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_wr_en,
    input  logic              m0_rd_en,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_done,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_wr_en,
    input  logic              m1_rd_en,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_done,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    input  logic              ram_busy,
    input  logic [DATA_W-1:0] ram_rd_data,
    input  logic              ram_rd_ready,
    output logic              ram_rd_ack
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);

    arb_state_t state_q, state_d;
    arb_op_t    op_q;
    logic       owner_q;
    logic [CW-1:0] cnt_q;

    logic [ARB_NMASTERS-1:0] req;
    logic win, win_wr, grant;
    logic strobe, rd_ok, timeout, done_set;

    assign req[0] = m0_wr_en | m0_rd_en;
    assign req[1] = m1_wr_en | m1_rd_en;
    assign grant  = (state_q == ARB_IDLE) && (|req);
    // Write takes precedence when a master raises both enables.
    assign win_wr = win ? m1_wr_en : m0_wr_en;

    mem_arb_pick u_pick (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .win   (win)
    );

    assign strobe   = (state_q == ARB_ISSUE) && !ram_busy;
    assign rd_ok    = (state_q == ARB_WAIT_RD) && ram_rd_ready;
    assign timeout  = (state_q == ARB_WAIT_RD) && !ram_rd_ready
                   && (cnt_q == CW'(RD_TIMEOUT - 1));
    assign done_set = (strobe && op_q == OP_WR) || rd_ok || timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) state_d = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (!ram_busy) begin
                    state_d = (op_q == OP_WR) ? ARB_DONE : ARB_WAIT_RD;
                end
            end
            ARB_WAIT_RD: begin
                if (rd_ok || timeout) state_d = ARB_DONE;
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Stray ready outside WAIT_RD is still acked so memory drains.
    always_comb begin
        ram_wr_en  = !rst && strobe && (op_q == OP_WR);
        ram_rd_en  = !rst && strobe && (op_q == OP_RD);
        ram_rd_ack = !rst && ram_rd_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_RD;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
            m0_done     <= 1'b0;
            m1_done     <= 1'b0;
            m0_err      <= 1'b0;
            m1_err      <= 1'b0;
        end else begin
            if (grant) begin
                ram_addr    <= win ? m1_addr : m0_addr;
                ram_wr_data <= win ? m1_wr_data : m0_wr_data;
                op_q        <= win_wr ? OP_WR : OP_RD;
                owner_q     <= win;
            end
            if (strobe) begin
                cnt_q <= '0;
            end else if (state_q == ARB_WAIT_RD && !ram_rd_ready) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (rd_ok && !owner_q) m0_rd_data <= ram_rd_data;
            if (rd_ok && owner_q)  m1_rd_data <= ram_rd_data;
            m0_done <= done_set && !owner_q;
            m1_done <= done_set && owner_q;
            m0_err  <= timeout && !owner_q;
            m1_err  <= timeout && owner_q;
        end
    end

endmodule
